dds_multiwave: RTL and testbench

- Parametrised direct digital synthesiser and the next generation of the team's fixed-tone DDS.
- Generates sine, square, triangle or sawtooth from a phase accumulator at a runtime-programmable frequency and phase offset.
- Output is sign-magnitude, feeding the modulation datapath.
- Configuration arrives over a valid/ready handshake and is applied only at a phase wrap (glitch-free retune) or while the generator is disabled.

---
 rtl/dds_multiwave.sv | 189 ++++++++++++++++++
 tb/tb_dds_multiwave.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_multiwave.sv
// dds_multiwave: multi-waveform direct digital synthesiser.
// Phase accumulator, wrap-synchronous retune, two-stage sign-magnitude output.
module dds_multiwave #(
    parameter int PHASE_W = 16,
    parameter int LUT_AW  = 6,
    parameter int OUT_W   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [PHASE_W-1:0] cfg_ftw,
    input  logic [PHASE_W-1:0] cfg_poff,
    input  logic [1:0]         cfg_mode,
    output logic [OUT_W-1:0]   sign_mag_output,
    output logic               sample_valid,
    output logic               phase_wrap
);
    localparam int PW     = PHASE_W;
    localparam int MAG_W  = OUT_W - 1;
    localparam int N      = 1 << LUT_AW;
    localparam int MAXM_I = (1 << MAG_W) - 1;
    localparam logic [MAG_W-1:0] MAXM = '1;

    // Quarter-wave sine entry in 2.30 fixed point (Taylor series), rounded.
    function automatic logic [MAG_W-1:0] sin_entry(input int i);
        longint x;
        longint x2;
        longint term;
        longint sum;
        longint r;
        x    = (64'sd1686629713 * longint'(2 * i + 1)) / longint'(2 * N);
        x2   = (x * x) >>> 30;
        term = x;
        sum  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -((term * x2) >>> 30) / longint'((2 * k) * (2 * k + 1));
            sum  = sum + term;
        end
        r = (sum * longint'(MAXM_I) + (64'sd1 <<< 29)) >>> 30;
        if (r > longint'(MAXM_I)) r = longint'(MAXM_I);
        if (r < 0) r = 0;
        return r[MAG_W-1:0];
    endfunction

    logic [N-1:0][MAG_W-1:0] lut;

    for (genvar g = 0; g < N; g++) begin : g_lut
        localparam logic [MAG_W-1:0] V = sin_entry(g);
        assign lut[g] = V;
    end

    typedef enum logic {IDLE, PENDING} cfg_state_t;

    cfg_state_t       state;
    logic [PW-1:0]    acc;
    logic [PW-1:0]    ftw_a;
    logic [PW-1:0]    poff_a;
    logic [1:0]       mode_a;
    logic [PW-1:0]    ftw_s;
    logic [PW-1:0]    poff_s;
    logic [1:0]       mode_s;
    logic [PW:0]      sum;
    logic [PW-1:0]    p_r;
    logic [1:0]       mode_r;
    logic             en_d1;
    logic [1:0]       q;
    logic [LUT_AW-1:0] idx;
    logic [MAG_W-1:0] tri_f;
    logic [OUT_W-1:0] saw_v;
    logic [OUT_W-1:0] saw_abs;
    logic [MAG_W-1:0] mag;
    logic             sgn;
    logic             unused_bits;

    assign sum = {1'b0, acc} + {1'b0, ftw_a};

    // Accumulator advance; carry-out becomes the one-cycle wrap pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            acc        <= '0;
            phase_wrap <= 1'b0;
        end else if (enable) begin
            acc        <= sum[PW-1:0];
            phase_wrap <= sum[PW];
        end else begin
            phase_wrap <= 1'b0;
        end
    end

    // Config handshake: capture to shadow, apply at wrap or while disabled
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            ftw_s     <= '0;
            poff_s    <= '0;
            mode_s    <= '0;
            ftw_a     <= '0;
            poff_a    <= '0;
            mode_a    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cfg_valid) begin
                        ftw_s     <= cfg_ftw;
                        poff_s    <= cfg_poff;
                        mode_s    <= cfg_mode;
                        state     <= PENDING;
                        cfg_ready <= 1'b0;
                    end
                end
                PENDING: begin
                    if (!enable || sum[PW]) begin
                        ftw_a     <= ftw_s;
                        poff_a    <= poff_s;
                        mode_a    <= mode_s;
                        state     <= IDLE;
                        cfg_ready <= 1'b1;
                    end
                end
            endcase
        end
    end

    // Stage 1: offset phase and mode, updated every cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            p_r    <= '0;
            mode_r <= '0;
        end else begin
            p_r    <= acc + poff_a;
            mode_r <= mode_a;
        end
    end

    assign q           = p_r[PW-1 -: 2];
    assign idx         = p_r[PW-3 -: LUT_AW];
    assign tri_f       = p_r[PW-3 -: MAG_W];
    assign saw_v       = {~p_r[PW-1], p_r[PW-2 -: MAG_W]};
    assign unused_bits = ^p_r;

    // Waveform shaping from the offset phase
    always_comb begin
        mag     = '0;
        sgn     = 1'b0;
        saw_abs = saw_v[OUT_W-1] ? (~saw_v + OUT_W'(1)) : saw_v;
        unique case (mode_r)
            2'd0: begin
                mag = q[0] ? lut[~idx] : lut[idx];
                sgn = q[1];
            end
            2'd1: begin
                mag = MAXM;
                sgn = p_r[PW-1];
            end
            2'd2: begin
                mag = q[0] ? ~tri_f : tri_f;
                sgn = q[1];
            end
            2'd3: begin
                mag = saw_abs[OUT_W-1] ? MAXM : saw_abs[MAG_W-1:0];
                sgn = saw_v[OUT_W-1];
            end
        endcase
    end

    // Stage 2: registered output, zero magnitude is never negative
    always_ff @(posedge clk) begin
        if (reset) begin
            sign_mag_output <= '0;
        end else begin
            sign_mag_output <= {sgn & (mag != '0), mag};
        end
    end

    // Sample-valid tracks enable through both pipeline stages
    always_ff @(posedge clk) begin
        if (reset) begin
            en_d1        <= 1'b0;
            sample_valid <= 1'b0;
        end else begin
            en_d1        <= enable;
            sample_valid <= en_d1;
        end
    end

endmodule

// File: tb/tb_dds_multiwave.sv
// tb_dds_multiwave: directed vectors and sequences for dds_multiwave.
// Default parameters: PHASE_W=16, LUT_AW=6, OUT_W=9.
module tb_dds_multiwave;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_ftw;
    logic [15:0] cfg_poff;
    logic [1:0]  cfg_mode;
    logic [8:0]  sign_mag_output;
    logic        sample_valid;
    logic        phase_wrap;

    int pass_cnt = 0;
    int total    = 0;

    typedef struct packed {
        logic [1:0]  mode;
        logic [15:0] poff;
        logic [8:0]  expv;
    } vec_t;

    vec_t vecs [19];

    dds_multiwave dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_ftw         (cfg_ftw),
        .cfg_poff        (cfg_poff),
        .cfg_mode        (cfg_mode),
        .sign_mag_output (sign_mag_output),
        .sample_valid    (sample_valid),
        .phase_wrap      (phase_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] expv);
        total++;
        if (act === expv) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        cfg_ftw   = '0;
        cfg_poff  = '0;
        cfg_mode  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic offer(input logic [15:0] f, input logic [15:0] p,
                         input logic [1:0] m);
        cfg_ftw   = f;
        cfg_poff  = p;
        cfg_mode  = m;
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    function automatic logic [8:0] sine_ref(input logic [15:0] p);
        logic [1:0] qq;
        int         i;
        int         m;
        real        v;
        qq = p[15:14];
        i  = qq[0] ? 63 - int'(p[13:8]) : int'(p[13:8]);
        v  = 255.0 * $sin(3.14159265358979 / 2.0 * (real'(i) + 0.5) / 64.0);
        m  = $rtoi(v + 0.5);
        return {qq[1] && (m != 0), m[7:0]};
    endfunction

    function automatic logic [15:0] acc_d(input int k);
        if (k <= 64) return 16'(k * 16'h0400);
        return 16'((k - 64) * 16'h0800);
    endfunction

    initial begin
        vecs[0]  = '{2'd0, 16'h0000, 9'h003};
        vecs[1]  = '{2'd0, 16'h4000, 9'h0FF};
        vecs[2]  = '{2'd0, 16'hC000, 9'h1FF};
        vecs[3]  = '{2'd0, 16'h8000, 9'h103};
        vecs[4]  = '{2'd0, 16'h0400, 9'h01C};
        vecs[5]  = '{2'd1, 16'h0000, 9'h0FF};
        vecs[6]  = '{2'd1, 16'h8000, 9'h1FF};
        vecs[7]  = '{2'd1, 16'h7FFF, 9'h0FF};
        vecs[8]  = '{2'd2, 16'h8000, 9'h000};
        vecs[9]  = '{2'd2, 16'h3FC0, 9'h0FF};
        vecs[10] = '{2'd2, 16'h4000, 9'h0FF};
        vecs[11] = '{2'd2, 16'hC000, 9'h1FF};
        vecs[12] = '{2'd2, 16'h1000, 9'h040};
        vecs[13] = '{2'd3, 16'h0000, 9'h1FF};
        vecs[14] = '{2'd3, 16'h8000, 9'h000};
        vecs[15] = '{2'd3, 16'hFF00, 9'h0FE};
        vecs[16] = '{2'd3, 16'hFF80, 9'h0FF};
        vecs[17] = '{2'd3, 16'h0100, 9'h1FE};
        vecs[18] = '{2'd3, 16'h7F80, 9'h101};

        // reset values
        do_reset();
        check("rst_out", 16'(sign_mag_output), 16'h0);
        check("rst_sv", 16'(sample_valid), 16'h0);
        check("rst_wrap", 16'(phase_wrap), 16'h0);
        check("rst_ready", 16'(cfg_ready), 16'h1);

        // static phase vectors: enable low, config applied at once
        for (int i = 0; i < 19; i++) begin
            offer(16'h0000, vecs[i].poff, vecs[i].mode);
            tick();
            tick();
            tick();
            check($sformatf("vec%0d", i), 16'(sign_mag_output),
                  16'(vecs[i].expv));
        end

        // sine period at ftw 0x0400
        do_reset();
        offer(16'h0400, 16'h0000, 2'd0);
        check("sin_ready_pend", 16'(cfg_ready), 16'h0);
        tick();
        check("sin_ready_applied", 16'(cfg_ready), 16'h1);
        enable = 1'b1;
        for (int k = 1; k <= 130; k++) begin
            tick();
            check($sformatf("sin_wrap_k%0d", k), 16'(phase_wrap),
                  16'((k % 64) == 0));
            if (k == 1) check("sin_sv_k1", 16'(sample_valid), 16'h0);
            if (k == 2) begin
                check("sin_sv_k2", 16'(sample_valid), 16'h1);
                check("sin_first", 16'(sign_mag_output), 16'h003);
            end
            if (k == 18) check("sin_4000", 16'(sign_mag_output), 16'h0FF);
            if (k == 50) check("sin_C000", 16'(sign_mag_output), 16'h1FF);
            if (k >= 2)
                check($sformatf("sin_k%0d", k), 16'(sign_mag_output),
                      16'(sine_ref(16'((k - 2) * 16'h0400))));
        end
        enable = 1'b0;
        tick();
        check("sv_hold", 16'(sample_valid), 16'h1);
        tick();
        check("sv_drop", 16'(sample_valid), 16'h0);
        tick();
        check("frozen_out", 16'(sign_mag_output), 16'(sine_ref(16'h0800)));
        check("frozen_wrap", 16'(phase_wrap), 16'h0);

        // square at half rate
        do_reset();
        offer(16'h8000, 16'h0000, 2'd1);
        tick();
        enable = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("sq_wrap_k%0d", k), 16'(phase_wrap),
                  16'((k % 2) == 0));
            if (k >= 2)
                check($sformatf("sq_k%0d", k), 16'(sign_mag_output),
                      (k % 2 == 0) ? 16'h0FF : 16'h1FF);
        end

        // deferred retune, second offer ignored while pending
        do_reset();
        offer(16'h0400, 16'h0000, 2'd0);
        tick();
        enable = 1'b1;
        for (int k = 1; k <= 4; k++) tick();
        offer(16'h0800, 16'h0000, 2'd0);
        check("ret_ready_low", 16'(cfg_ready), 16'h0);
        offer(16'h0200, 16'h4000, 2'd3);
        check("ret_ready_still", 16'(cfg_ready), 16'h0);
        for (int k = 7; k <= 100; k++) begin
            tick();
            check($sformatf("ret_ready_k%0d", k), 16'(cfg_ready),
                  16'(k >= 64));
            check($sformatf("ret_wrap_k%0d", k), 16'(phase_wrap),
                  16'(k == 64 || k == 96));
            check($sformatf("ret_out_k%0d", k), 16'(sign_mag_output),
                  16'(sine_ref(acc_d(k - 2))));
        end

        // phase offset and deferred offset change
        do_reset();
        offer(16'h0400, 16'h4000, 2'd0);
        tick();
        enable = 1'b1;
        tick();
        tick();
        check("poff_first", 16'(sign_mag_output), 16'h0FF);
        offer(16'h0400, 16'h0000, 2'd0);
        for (int k = 4; k <= 70; k++) begin
            tick();
            check($sformatf("poff_k%0d", k), 16'(sign_mag_output),
                  16'(sine_ref(16'((k - 2) * 16'h0400
                               + ((k >= 66) ? 0 : 16'h4000)))));
        end

        // reset while a config is pending discards it
        do_reset();
        offer(16'h0400, 16'h0000, 2'd0);
        tick();
        enable = 1'b1;
        tick();
        tick();
        tick();
        offer(16'h0800, 16'h4000, 2'd1);
        check("mid_pending", 16'(cfg_ready), 16'h0);
        reset = 1'b1;
        tick();
        check("mid_rst_out", 16'(sign_mag_output), 16'h0);
        check("mid_rst_sv", 16'(sample_valid), 16'h0);
        check("mid_rst_wrap", 16'(phase_wrap), 16'h0);
        check("mid_rst_ready", 16'(cfg_ready), 16'h1);
        reset  = 1'b0;
        enable = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check("mid_discard_out", 16'(sign_mag_output), 16'h003);
        check("mid_discard_ready", 16'(cfg_ready), 16'h1);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check("mid_zero_ftw_out", 16'(sign_mag_output), 16'h003);
        check("mid_zero_ftw_wrap", 16'(phase_wrap), 16'h0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
